router_port: RTL and testbench

ROUTER_PORT -- requirements
Module: router_port

---
 rtl/router_port_pkg.sv | 36 +++
 rtl/router_port_fifo.sv | 58 +++++
 rtl/router_port.sv | 150 +++++++++++++++
 tb/tb_router_port.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/router_port_pkg.sv
// Shared types and constants for the router endpoint port.
package router_port_pkg;

    localparam int BYTES_PER_PKT = 4;

    // Index of the final byte of a packet in a 2-bit byte counter.
    localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_PKT - 1);

    typedef struct packed {
        logic [3:0]  sourceID;
        logic [3:0]  destID;
        logic [23:0] data;
    } pkt_t;

    typedef enum logic {
        RX_IDLE,
        RX_RECV
    } rx_state_t;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_WAIT,
        TX_SEND
    } tx_state_t;

    // Wire byte idx of a packet: byte0 = {sourceID, destID}, then data MSB first.
    function automatic logic [7:0] pkt_byte(input pkt_t p, input logic [1:0] idx);
        case (idx)
            2'd0:    pkt_byte = {p.sourceID, p.destID};
            2'd1:    pkt_byte = p.data[23:16];
            2'd2:    pkt_byte = p.data[15:8];
            default: pkt_byte = p.data[7:0];
        endcase
    endfunction

endpackage

// File: rtl/router_port_fifo.sv
// pkt_fifo: power-of-2 depth FIFO with combinational head read.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module pkt_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_empty,
    output logic             o_full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == CW'(DEPTH));
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_data    = r_mem[r_rd_ptr];

    // Storage write port.
    // NOTE: the array is not reset; r_count gates visibility, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally modulo DEPTH.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/router_port.sv
// router_port: byte-serial endpoint link <-> packet interface to the core.
// Ingress assembles 4-byte wire packets into a packet FIFO; egress serialises
// one held packet at a time once the endpoint signals it is free.
module router_port
    import router_port_pkg::*;
#(
    parameter int RXDEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_b,
    output logic       free_outbound,
    input  logic       put_outbound,
    input  logic [7:0] payload_outbound,
    input  logic       free_inbound,
    output logic       put_inbound,
    output logic [7:0] payload_inbound,
    output pkt_t       rx_pkt,
    output logic       rx_valid,
    input  logic       rx_pop,
    input  pkt_t       tx_pkt,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       rx_err
);

    // ---------------- ingress ----------------
    rx_state_t   r_rx_state;
    logic [1:0]  r_rx_cnt;
    logic [7:0]  r_rx_byte0;
    logic [7:0]  r_rx_byte1;
    logic [7:0]  r_rx_byte2;
    logic        r_rx_err;
    logic        w_rx_push;
    logic [31:0] w_rx_word;
    logic [31:0] w_rx_head;
    logic        w_fifo_full;
    logic        w_fifo_empty;

    // Final byte goes straight from the wire into the FIFO, so the packet is visible next cycle.
    assign w_rx_push = (r_rx_state == RX_RECV) && put_outbound && (r_rx_cnt == LAST_BYTE);
    assign w_rx_word = {r_rx_byte0, r_rx_byte1, r_rx_byte2, payload_outbound};

    // Ingress framing FSM: collect bytes, abort on a gap, ignore puts while the buffer is full.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_rx_state <= RX_IDLE;
            r_rx_cnt   <= 2'd0;
            r_rx_byte0 <= 8'h00;
            r_rx_byte1 <= 8'h00;
            r_rx_byte2 <= 8'h00;
            r_rx_err   <= 1'b0;
        end else begin
            r_rx_err <= 1'b0;
            case (r_rx_state)
                RX_IDLE: begin
                    if (put_outbound && !w_fifo_full) begin
                        r_rx_byte0 <= payload_outbound;
                        r_rx_cnt   <= 2'd1;
                        r_rx_state <= RX_RECV;
                    end
                end
                RX_RECV: begin
                    if (put_outbound) begin
                        if (r_rx_cnt == 2'd1) r_rx_byte1 <= payload_outbound;
                        if (r_rx_cnt == 2'd2) r_rx_byte2 <= payload_outbound;
                        if (r_rx_cnt == LAST_BYTE) begin
                            r_rx_cnt   <= 2'd0;
                            r_rx_state <= RX_IDLE;
                        end else begin
                            r_rx_cnt <= r_rx_cnt + 2'd1;
                        end
                    end else begin
                        r_rx_err   <= 1'b1;
                        r_rx_cnt   <= 2'd0;
                        r_rx_state <= RX_IDLE;
                    end
                end
                default: r_rx_state <= RX_IDLE;
            endcase
        end
    end

    pkt_fifo #(
        .WIDTH ($bits(pkt_t)),
        .DEPTH (RXDEPTH)
    ) u_rx_fifo (
        .clk     (clk),
        .rst_b   (rst_b),
        .i_push  (w_rx_push),
        .i_data  (w_rx_word),
        .i_pop   (rx_pop),
        .o_data  (w_rx_head),
        .o_empty (w_fifo_empty),
        .o_full  (w_fifo_full)
    );

    // rst_b gating holds the handshake low during reset, when the FSM alone would read idle.
    assign free_outbound = rst_b && (r_rx_state == RX_IDLE) && !w_fifo_full;
    assign rx_pkt        = w_rx_head;
    assign rx_valid      = !w_fifo_empty;
    assign rx_err        = r_rx_err;

    // ---------------- egress ----------------
    tx_state_t  r_tx_state;
    logic [1:0] r_tx_cnt;
    pkt_t       r_tx_hold;

    // Egress FSM: hold one packet, wait for endpoint free, then stream four bytes.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_tx_state <= TX_IDLE;
            r_tx_cnt   <= 2'd0;
            r_tx_hold  <= '0;
        end else begin
            case (r_tx_state)
                TX_IDLE: begin
                    if (tx_valid) begin
                        r_tx_hold  <= tx_pkt;
                        r_tx_state <= TX_WAIT;
                    end
                end
                TX_WAIT: begin
                    if (free_inbound) begin
                        r_tx_cnt   <= 2'd0;
                        r_tx_state <= TX_SEND;
                    end
                end
                TX_SEND: begin
                    r_tx_cnt <= r_tx_cnt + 2'd1;
                    if (r_tx_cnt == LAST_BYTE) r_tx_state <= TX_IDLE;
                end
                default: r_tx_state <= TX_IDLE;
            endcase
        end
    end

    assign tx_ready    = rst_b && (r_tx_state == TX_IDLE);
    assign put_inbound = (r_tx_state == TX_SEND);

    // Select the outgoing byte; bus is forced to zero whenever no byte is being sent.
    always_comb begin
        // NOTE: default assigned first so every path drives the output and no latch is inferred.
        // NOTE: blocking assignments here -- this is combinational, not state.
        payload_inbound = 8'h00;
        if (r_tx_state == TX_SEND) begin
            payload_inbound = pkt_byte(r_tx_hold, r_tx_cnt);
        end
    end

endmodule

// File: tb/tb_router_port.sv
// Directed testbench for router_port: framing, buffering, egress timing, reset.
module tb_router_port;
    import router_port_pkg::*;

    logic       clk = 1'b0;
    logic       rst_b;
    logic       free_outbound;
    logic       put_outbound;
    logic [7:0] payload_outbound;
    logic       free_inbound;
    logic       put_inbound;
    logic [7:0] payload_inbound;
    pkt_t       rx_pkt;
    logic       rx_valid;
    logic       rx_pop;
    pkt_t       tx_pkt;
    logic       tx_valid;
    logic       tx_ready;
    logic       rx_err;

    // standalone buffer instance to exercise push into a truly full FIFO
    logic       f_push;
    logic       f_pop;
    logic [7:0] f_din;
    logic [7:0] f_dout;
    logic       f_empty;
    logic       f_full;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    router_port #(.RXDEPTH(4)) dut (
        .clk              (clk),
        .rst_b            (rst_b),
        .free_outbound    (free_outbound),
        .put_outbound     (put_outbound),
        .payload_outbound (payload_outbound),
        .free_inbound     (free_inbound),
        .put_inbound      (put_inbound),
        .payload_inbound  (payload_inbound),
        .rx_pkt           (rx_pkt),
        .rx_valid         (rx_valid),
        .rx_pop           (rx_pop),
        .tx_pkt           (tx_pkt),
        .tx_valid         (tx_valid),
        .tx_ready         (tx_ready),
        .rx_err           (rx_err)
    );

    pkt_fifo #(.WIDTH(8), .DEPTH(4)) u_fifo (
        .clk     (clk),
        .rst_b   (rst_b),
        .i_push  (f_push),
        .i_data  (f_din),
        .i_pop   (f_pop),
        .o_data  (f_dout),
        .o_empty (f_empty),
        .o_full  (f_full)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_pkt(input logic [31:0] w, input logic pop_last);
        for (int i = 0; i < 4; i++) begin
            put_outbound     = 1'b1;
            payload_outbound = w[31-8*i -: 8];
            rx_pop           = pop_last && (i == 3);
            tick();
        end
        put_outbound     = 1'b0;
        payload_outbound = 8'h00;
        rx_pop           = 1'b0;
    endtask

    task automatic test_reset();
        rst_b = 1'b0;
        put_outbound = 1'b0; payload_outbound = 8'h00; free_inbound = 1'b0;
        rx_pop = 1'b0; tx_pkt = '0; tx_valid = 1'b0;
        f_push = 1'b0; f_pop = 1'b0; f_din = 8'h00;
        repeat (3) tick();
        total_cnt++; if (free_outbound !== 1'b0) $display("FAIL reset_free_outbound: got %b want 0", free_outbound); else pass_cnt++;
        total_cnt++; if (put_inbound !== 1'b0) $display("FAIL reset_put_inbound: got %b want 0", put_inbound); else pass_cnt++;
        total_cnt++; if (payload_inbound !== 8'h00) $display("FAIL reset_payload_inbound: got %h want 00", payload_inbound); else pass_cnt++;
        total_cnt++; if (tx_ready !== 1'b0) $display("FAIL reset_tx_ready: got %b want 0", tx_ready); else pass_cnt++;
        total_cnt++; if (rx_valid !== 1'b0) $display("FAIL reset_rx_valid: got %b want 0", rx_valid); else pass_cnt++;
        total_cnt++; if (rx_err !== 1'b0) $display("FAIL reset_rx_err: got %b want 0", rx_err); else pass_cnt++;
        rst_b = 1'b1;
        tick();
        total_cnt++; if (free_outbound !== 1'b1) $display("FAIL post_reset_free_outbound: got %b want 1", free_outbound); else pass_cnt++;
        total_cnt++; if (tx_ready !== 1'b1) $display("FAIL post_reset_tx_ready: got %b want 1", tx_ready); else pass_cnt++;
    endtask

    task automatic test_rx_basic();
        logic [7:0] bytes [4];
        bytes[0] = 8'h12; bytes[1] = 8'hAA; bytes[2] = 8'hBB; bytes[3] = 8'hCC;
        for (int i = 0; i < 4; i++) begin
            put_outbound     = 1'b1;
            payload_outbound = bytes[i];
            tick();
            if (i < 3) begin
                total_cnt++; if (free_outbound !== 1'b0) $display("FAIL rx_basic_free_during_byte%0d: got %b want 0", i + 1, free_outbound); else pass_cnt++;
                total_cnt++; if (rx_valid !== 1'b0) $display("FAIL rx_basic_early_valid_byte%0d: got %b want 0", i + 1, rx_valid); else pass_cnt++;
            end
        end
        put_outbound = 1'b0; payload_outbound = 8'h00;
        total_cnt++; if (rx_valid !== 1'b1) $display("FAIL rx_basic_valid: got %b want 1", rx_valid); else pass_cnt++;
        total_cnt++; if (rx_pkt !== 32'h12AABBCC) $display("FAIL rx_basic_pkt: got %h want 12aabbcc", rx_pkt); else pass_cnt++;
        total_cnt++; if (rx_pkt.sourceID !== 4'h1 || rx_pkt.destID !== 4'h2) $display("FAIL rx_basic_ids: got src %h dst %h want 1 2", rx_pkt.sourceID, rx_pkt.destID); else pass_cnt++;
        total_cnt++; if (free_outbound !== 1'b1) $display("FAIL rx_basic_free_after: got %b want 1", free_outbound); else pass_cnt++;
        rx_pop = 1'b1; tick(); rx_pop = 1'b0;
        total_cnt++; if (rx_valid !== 1'b0) $display("FAIL rx_basic_pop_empty: got %b want 0", rx_valid); else pass_cnt++;
    endtask

    task automatic test_fill();
        logic [31:0] pk [5];
        for (int i = 0; i < 5; i++) pk[i] = 32'h31000010 + 32'(i);
        for (int i = 0; i < 4; i++) send_pkt(pk[i], 1'b0);
        total_cnt++; if (free_outbound !== 1'b0) $display("FAIL fill_free_when_full: got %b want 0", free_outbound); else pass_cnt++;
        total_cnt++; if (rx_pkt !== pk[0]) $display("FAIL fill_head: got %h want %h", rx_pkt, pk[0]); else pass_cnt++;
        // put while full must be ignored (no framing started, so no abort follows)
        put_outbound = 1'b1; payload_outbound = 8'hEE; tick();
        put_outbound = 1'b0; payload_outbound = 8'h00; tick();
        total_cnt++; if (rx_err !== 1'b0) $display("FAIL fill_put_while_full_err: got %b want 0", rx_err); else pass_cnt++;
        rx_pop = 1'b1; tick(); rx_pop = 1'b0;
        total_cnt++; if (free_outbound !== 1'b1) $display("FAIL fill_free_after_pop: got %b want 1", free_outbound); else pass_cnt++;
        total_cnt++; if (rx_pkt !== pk[1]) $display("FAIL fill_head_after_pop: got %h want %h", rx_pkt, pk[1]); else pass_cnt++;
        send_pkt(pk[4], 1'b0);
        total_cnt++; if (free_outbound !== 1'b0) $display("FAIL fill_full_again: got %b want 0", free_outbound); else pass_cnt++;
        for (int k = 1; k < 5; k++) begin
            total_cnt++; if (rx_valid !== 1'b1 || rx_pkt !== pk[k]) $display("FAIL fill_drain%0d: got v=%b %h want v=1 %h", k, rx_valid, rx_pkt, pk[k]); else pass_cnt++;
            rx_pop = 1'b1; tick(); rx_pop = 1'b0;
        end
        total_cnt++; if (rx_valid !== 1'b0) $display("FAIL fill_drained_valid: got %b want 0", rx_valid); else pass_cnt++;
    endtask

    task automatic test_push_with_pop();
        logic [31:0] pk [5];
        for (int i = 0; i < 5; i++) pk[i] = 32'h56000100 + 32'(i);
        for (int i = 0; i < 4; i++) send_pkt(pk[i], 1'b0);
        rx_pop = 1'b1; tick(); rx_pop = 1'b0;
        // final byte lands in the same cycle the core pops pk[1]
        send_pkt(pk[4], 1'b1);
        total_cnt++; if (free_outbound !== 1'b1) $display("FAIL pushpop_free: got %b want 1", free_outbound); else pass_cnt++;
        for (int k = 2; k < 5; k++) begin
            total_cnt++; if (rx_valid !== 1'b1 || rx_pkt !== pk[k]) $display("FAIL pushpop_order%0d: got v=%b %h want v=1 %h", k, rx_valid, rx_pkt, pk[k]); else pass_cnt++;
            rx_pop = 1'b1; tick(); rx_pop = 1'b0;
        end
        total_cnt++; if (rx_valid !== 1'b0) $display("FAIL pushpop_empty: got %b want 0", rx_valid); else pass_cnt++;
    endtask

    task automatic test_rx_abort();
        put_outbound = 1'b1; payload_outbound = 8'h9A; tick();
        payload_outbound = 8'h11; tick();
        put_outbound = 1'b0; payload_outbound = 8'h00;
        total_cnt++; if (rx_err !== 1'b0) $display("FAIL abort_err_early: got %b want 0", rx_err); else pass_cnt++;
        tick();
        total_cnt++; if (rx_err !== 1'b1) $display("FAIL abort_err_pulse: got %b want 1", rx_err); else pass_cnt++;
        total_cnt++; if (rx_valid !== 1'b0) $display("FAIL abort_no_push: got %b want 0", rx_valid); else pass_cnt++;
        tick();
        total_cnt++; if (rx_err !== 1'b0) $display("FAIL abort_err_one_cycle: got %b want 0", rx_err); else pass_cnt++;
        send_pkt(32'h9A445566, 1'b0);
        total_cnt++; if (rx_valid !== 1'b1 || rx_pkt !== 32'h9A445566) $display("FAIL abort_next_pkt: got v=%b %h want v=1 9a445566", rx_valid, rx_pkt); else pass_cnt++;
        rx_pop = 1'b1; tick(); rx_pop = 1'b0;
    endtask

    task automatic test_tx();
        logic [7:0] exp_b [4];
        exp_b[0] = 8'h34; exp_b[1] = 8'h01; exp_b[2] = 8'h02; exp_b[3] = 8'h03;
        total_cnt++; if (tx_ready !== 1'b1) $display("FAIL tx_ready_idle: got %b want 1", tx_ready); else pass_cnt++;
        tx_pkt = '{sourceID: 4'h3, destID: 4'h4, data: 24'h010203};
        tx_valid = 1'b1; free_inbound = 1'b0;
        tick();
        tx_valid = 1'b0; tx_pkt = '0;
        total_cnt++; if (tx_ready !== 1'b0) $display("FAIL tx_ready_wait: got %b want 0", tx_ready); else pass_cnt++;
        for (int i = 0; i < 5; i++) begin
            tick();
            total_cnt++; if (put_inbound !== 1'b0 || payload_inbound !== 8'h00) $display("FAIL tx_wait_idle_bus%0d: got put=%b %h want put=0 00", i, put_inbound, payload_inbound); else pass_cnt++;
        end
        free_inbound = 1'b1;
        #1;
        total_cnt++; if (put_inbound !== 1'b0) $display("FAIL tx_no_put_same_cycle: got %b want 0", put_inbound); else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            tick();
            free_inbound = 1'b0;
            total_cnt++; if (put_inbound !== 1'b1 || payload_inbound !== exp_b[i]) $display("FAIL tx_byte%0d: got put=%b %h want put=1 %h", i, put_inbound, payload_inbound, exp_b[i]); else pass_cnt++;
        end
        tick();
        total_cnt++; if (put_inbound !== 1'b0 || payload_inbound !== 8'h00) $display("FAIL tx_after_send: got put=%b %h want put=0 00", put_inbound, payload_inbound); else pass_cnt++;
        total_cnt++; if (tx_ready !== 1'b1) $display("FAIL tx_ready_after: got %b want 1", tx_ready); else pass_cnt++;
    endtask

    task automatic test_simultaneous();
        logic [31:0] rw;
        logic [31:0] tw;
        rw = 32'h56DEAD01;
        tw = 32'h78A1B2C3;
        tx_pkt = tw; tx_valid = 1'b1;
        put_outbound = 1'b1; payload_outbound = rw[31:24];
        tick();
        tx_valid = 1'b0; free_inbound = 1'b1; payload_outbound = rw[23:16];
        tick();
        free_inbound = 1'b0;
        total_cnt++; if (put_inbound !== 1'b1 || payload_inbound !== tw[31:24]) $display("FAIL simul_tx0: got put=%b %h want put=1 %h", put_inbound, payload_inbound, tw[31:24]); else pass_cnt++;
        payload_outbound = rw[15:8];
        tick();
        total_cnt++; if (payload_inbound !== tw[23:16]) $display("FAIL simul_tx1: got %h want %h", payload_inbound, tw[23:16]); else pass_cnt++;
        payload_outbound = rw[7:0];
        tick();
        put_outbound = 1'b0; payload_outbound = 8'h00;
        total_cnt++; if (payload_inbound !== tw[15:8]) $display("FAIL simul_tx2: got %h want %h", payload_inbound, tw[15:8]); else pass_cnt++;
        total_cnt++; if (rx_valid !== 1'b1 || rx_pkt !== rw) $display("FAIL simul_rx: got v=%b %h want v=1 %h", rx_valid, rx_pkt, rw); else pass_cnt++;
        tick();
        total_cnt++; if (payload_inbound !== tw[7:0]) $display("FAIL simul_tx3: got %h want %h", payload_inbound, tw[7:0]); else pass_cnt++;
        rx_pop = 1'b1; tick(); rx_pop = 1'b0;
        tx_pkt = '0;
    endtask

    task automatic test_fifo_full_pop();
        logic [7:0] vals [4];
        vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44;
        f_push = 1'b1;
        for (int i = 0; i < 4; i++) begin
            f_din = vals[i];
            tick();
        end
        f_push = 1'b0;
        total_cnt++; if (f_full !== 1'b1 || f_dout !== 8'h11) $display("FAIL fifo_full: got full=%b %h want full=1 11", f_full, f_dout); else pass_cnt++;
        f_push = 1'b1; f_din = 8'h66; tick(); f_push = 1'b0;
        f_push = 1'b1; f_pop = 1'b1; f_din = 8'h55; tick(); f_push = 1'b0; f_pop = 1'b0;
        total_cnt++; if (f_full !== 1'b1 || f_dout !== 8'h22) $display("FAIL fifo_full_pushpop: got full=%b %h want full=1 22", f_full, f_dout); else pass_cnt++;
        vals[0] = 8'h22; vals[1] = 8'h33; vals[2] = 8'h44; vals[3] = 8'h55;
        for (int i = 0; i < 4; i++) begin
            total_cnt++; if (f_empty !== 1'b0 || f_dout !== vals[i]) $display("FAIL fifo_drain%0d: got e=%b %h want e=0 %h", i, f_empty, f_dout, vals[i]); else pass_cnt++;
            f_pop = 1'b1; tick(); f_pop = 1'b0;
        end
        total_cnt++; if (f_empty !== 1'b1) $display("FAIL fifo_empty: got %b want 1", f_empty); else pass_cnt++;
    endtask

    task automatic test_tx_reset();
        pkt_t p;
        p = '{sourceID: 4'hC, destID: 4'hD, data: 24'hE0F1A2};
        tx_pkt = p; tx_valid = 1'b1; free_inbound = 1'b1;
        tick();
        tx_valid = 1'b0; put_outbound = 1'b1; payload_outbound = 8'h77;
        tick();
        payload_outbound = 8'h88;
        tick();
        payload_outbound = 8'h99;
        tick();
        total_cnt++; if (put_inbound !== 1'b1 || payload_inbound !== 8'hF1) $display("FAIL txrst_byte2: got put=%b %h want put=1 f1", put_inbound, payload_inbound); else pass_cnt++;
        rst_b = 1'b0; put_outbound = 1'b0; payload_outbound = 8'h00;
        #1;
        total_cnt++; if (put_inbound !== 1'b0 || payload_inbound !== 8'h00) $display("FAIL txrst_immediate: got put=%b %h want put=0 00", put_inbound, payload_inbound); else pass_cnt++;
        total_cnt++; if (tx_ready !== 1'b0 || free_outbound !== 1'b0) $display("FAIL txrst_handshakes: got rdy=%b free=%b want 0 0", tx_ready, free_outbound); else pass_cnt++;
        repeat (2) tick();
        rst_b = 1'b1; free_inbound = 1'b0; tx_pkt = '0;
        tick();
        total_cnt++; if (tx_ready !== 1'b1 || put_inbound !== 1'b0) $display("FAIL txrst_release: got rdy=%b put=%b want 1 0", tx_ready, put_inbound); else pass_cnt++;
        total_cnt++; if (rx_err !== 1'b0 || rx_valid !== 1'b0) $display("FAIL txrst_rx_discard: got err=%b v=%b want 0 0", rx_err, rx_valid); else pass_cnt++;
        total_cnt++; if (free_outbound !== 1'b1) $display("FAIL txrst_free: got %b want 1", free_outbound); else pass_cnt++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_rx_basic();
        test_fill();
        test_push_with_pop();
        test_rx_abort();
        test_tx();
        test_simultaneous();
        test_fifo_full_pop();
        test_tx_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
